core_com_receiver: RTL and testbench
====================================

CORE_COM_RECEIVER -- requirements
Module: core_com_receiver

Interface
REQ-001 SHALL have parameter WORD_W, default 23, meaning the frame payload width in bits, equal to the core pData width.
REQ-002 SHALL have port fastClk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port portBus, input, 1 bit: frame-enable from the sender, high for the whole frame.
REQ-005 SHALL have port dataBus, input, 1 bit: serial payload, MSB first, one bit per fastClk while portBus=1.
REQ-006 SHALL have port arag, output, 1 bit: frame acknowledge to the sender.
REQ-007 SHALL have port rxData, output, WORD_W bits: last received word.
REQ-008 SHALL have port rxValid, output, 1 bit: rxData holds an unconsumed word.
REQ-009 SHALL have port rxReady, input, 1 bit: the consumer takes rxData when rxValid and rxReady are both high.
REQ-010 SHALL have port cycle, output, 16 bits: count of accepted frames, wrapping 16'hFFFF->0.
REQ-011 SHALL have port frameErr, output, 1 bit: one-cycle pulse on a truncated frame.

Function
REQ-012 SHALL implement states IDLE, SHIFT, LOAD, ACK, WAITLOW.
REQ-013 IDLE: when portBus=1, SHALL capture dataBus as bit WORD_W-1, set bitCnt=1, and go to SHIFT.
REQ-014 SHIFT: when portBus=1, SHALL capture dataBus into the next lower bit and increment bitCnt; the edge capturing bit 0 (bitCnt reaches WORD_W) SHALL go to LOAD.
REQ-015 SHIFT: when portBus=0 before WORD_W bits, SHALL discard the partial word, pulse frameErr for exactly one cycle, and go to IDLE; rxData, rxValid and cycle SHALL remain unchanged.
REQ-016 LOAD: if rxValid=0, or rxValid&rxReady in this cycle, SHALL load rxData, set rxValid=1 and arag=1, increment cycle, and go to ACK at the next edge.
REQ-017 LOAD: otherwise SHALL stall with arag=0 indefinitely (backpressure); the shifted word SHALL be held intact.
REQ-018 Latency: with a free output register, rxValid and arag SHALL rise on the edge following the edge that captured bit 0.
REQ-019 ACK: arag SHALL be high for exactly one cycle, then low; the next state SHALL be WAITLOW.
REQ-020 WAITLOW: SHALL ignore dataBus and go to IDLE on the first cycle with portBus=0; a portBus held high never starts a new frame.
REQ-021 rxValid SHALL clear on the edge where rxValid&rxReady, unless a new load occurs on that same edge, in which case rxValid SHALL stay 1 with the new data.
REQ-022 rxData SHALL be stable while rxValid=1 and not consumed.
REQ-023 The cycle counter SHALL increment only in LOAD-success; it SHALL wrap without any flag.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, bitCnt=0, shift register=0, rxData=0, rxValid=0, arag=0, cycle=0, frameErr=0.
REQ-025 Reset deasserted mid-frame SHALL leave the block in IDLE; if portBus is still high, the next sampled bit SHALL be treated as a new MSB.

Structure
REQ-026 Package core_com_pkg SHALL hold WORD_W=23, the bit-counter width CNT_W=5, and the state encoding constants.
REQ-027 The serial-in/parallel-out shifter with bitCnt SHALL be sub-module core_com_shifter (inputs: shift enable, clear, bit; outputs: word, full flag).
REQ-028 All outputs SHALL be registered.

Verification
REQ-029 Frame 23'h5A5A5A with rxReady=1 -> rxData=23'h5A5A5A, rxValid and arag high one cycle after the last bit, cycle=1.
REQ-030 portBus drops after 10 bits -> frameErr pulses one cycle; rxValid=0, cycle=0; the next full frame 23'h000001 is received correctly.
REQ-031 Two frames 23'h111111 then 23'h222222 with rxReady=0 -> the second frame stalls in LOAD with arag=0; rxReady=1 for one cycle -> 23'h111111 is consumed and 23'h222222 loads on the same edge with rxValid held at 1.
REQ-032 cycle preset by sending 65535 frames, then one more -> cycle=16'h0000.
REQ-033 rst asserted during bit 12 of a frame -> all outputs 0 immediately; portBus held high through 30 cycles after reset -> one frame captured from the post-reset bits, then WAITLOW until portBus=0.
REQ-034 portBus held high for 40 cycles -> exactly one frame is accepted and one arag pulse is produced.

Source files
------------

// File: rtl/core_com_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// core_com_pkg
// Shared constants for the serial frame receiver: payload width, bit-counter
// width and FSM state encoding.
// Revision: 1.0
// ============================================================================
package core_com_pkg;

  localparam int WORD_W = 23;
  localparam int CNT_W  = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_WAITLOW = 3'd4;

endpackage : core_com_pkg
`default_nettype wire

// File: rtl/core_com_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// core_com_shifter
// Serial-in / parallel-out register, MSB first, with its own bit counter.
// A shift with clear starts a fresh word: the bit lands at the MSB and the
// count restarts at one. Clear alone discards the partial word.
// Revision: 1.0
// ============================================================================
module core_com_shifter #(
  parameter int WORD_W = core_com_pkg::WORD_W,
  parameter int CNT_W  = core_com_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word,
  output logic              full,
  output logic              last
);

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] idx;

  // Position of the next bit to be written (counts down from the MSB).
  assign idx  = CNT_W'(WORD_W - 1) - bit_cnt;
  assign full = (bit_cnt == CNT_W'(WORD_W));
  // The next shift writes bit 0 and completes the word.
  assign last = (bit_cnt == CNT_W'(WORD_W - 1));

  // Capture serial bits into descending word positions and count them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      if (clear) begin
        word             <= '0;
        word[WORD_W-1]   <= bit_in;
        bit_cnt          <= CNT_W'(1);
      end else if (!full) begin
        word[idx] <= bit_in;
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
    end else if (clear) begin
      word    <= '0;
      bit_cnt <= '0;
    end
  end

endmodule : core_com_shifter
`default_nettype wire

// File: rtl/core_com_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// core_com_receiver
// Receives MSB-first serial frames framed by portBus, hands complete words to
// a valid/ready consumer, acknowledges each accepted frame with a one-cycle
// arag pulse and counts accepted frames. Truncated frames raise frameErr.
// Revision: 1.0
// ============================================================================
module core_com_receiver #(
  parameter int WORD_W = core_com_pkg::WORD_W
) (
  input  logic              fastClk,
  input  logic              rst,
  input  logic              portBus,
  input  logic              dataBus,
  output logic              arag,
  output logic [WORD_W-1:0] rxData,
  output logic              rxValid,
  input  logic              rxReady,
  output logic [15:0]       cycle,
  output logic              frameErr
);

  import core_com_pkg::*;

  logic [2:0]        state;
  logic [WORD_W-1:0] word;
  logic              word_full;
  logic              word_last;
  logic              shift_en;
  logic              shift_clear;
  logic              load_ok;

  // Sample bits only while the frame is open in IDLE or SHIFT; IDLE always
  // restarts the word, and a dropped frame in SHIFT discards it.
  assign shift_en    = portBus && ((state == ST_IDLE) || (state == ST_SHIFT));
  assign shift_clear = (state == ST_IDLE) || ((state == ST_SHIFT) && !portBus);

  // The output register is free when empty or being consumed this cycle.
  assign load_ok = (state == ST_LOAD) && (!rxValid || rxReady);

  core_com_shifter #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk      (fastClk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (shift_clear),
    .bit_in   (dataBus),
    .word     (word),
    .full     (word_full),
    .last     (word_last)
  );

  // Frame sequencing, output load, acknowledge and frame counting.
  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rxData   <= '0;
      arag     <= 1'b0;
      cycle    <= 16'h0000;
      frameErr <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (portBus) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (portBus) begin
            if (word_last) state <= ST_LOAD;
          end else begin
            frameErr <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // Stalls here under backpressure; the shifter holds the word.
          if (load_ok) begin
            rxData <= word;
            arag   <= 1'b1;
            cycle  <= cycle + 16'd1;
            state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          arag  <= 1'b0;
          state <= ST_WAITLOW;
        end
        ST_WAITLOW: begin
          if (!portBus) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Valid flag: set on a load, cleared on consumption without a new load.
  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      rxValid <= 1'b0;
    end else if (load_ok) begin
      rxValid <= 1'b1;
    end else if (rxValid && rxReady) begin
      rxValid <= 1'b0;
    end
  end

  logic unused_full;
  assign unused_full = word_full;

endmodule : core_com_receiver
`default_nettype wire

// File: tb/tb_core_com_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_core_com_receiver
// Directed frames with hand-computed expectations; a scoreboard queue holds
// the expected {cycle, word} for every consumer handshake.
// Revision: 1.0
// ============================================================================
module tb_core_com_receiver;

  logic        fastClk = 1'b0;
  logic        rst;
  logic        portBus;
  logic        dataBus;
  logic        rxReady;
  logic        arag;
  logic        rxValid;
  logic        frameErr;
  logic [22:0] rxData;
  logic [15:0] cycle;

  int          total = 0;
  int          bad   = 0;
  logic [38:0] exp_q[$];
  int          arag_pulses = 0;
  int          err_pulses  = 0;
  logic        arag_prev   = 1'b0;
  logic        err_prev    = 1'b0;
  int          arag_mark;

  always #5 fastClk = ~fastClk;

  core_com_receiver #(.WORD_W(23)) dut (
    .fastClk  (fastClk),
    .rst      (rst),
    .portBus  (portBus),
    .dataBus  (dataBus),
    .arag     (arag),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxReady  (rxReady),
    .cycle    (cycle),
    .frameErr (frameErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fastClk);
    #1;
  endtask

  task automatic send_word(input logic [22:0] w, input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      portBus = 1'b1;
      dataBus = w[22-i];
      tick();
    end
    if (drop) portBus = 1'b0;
    dataBus = 1'b0;
  endtask

  // Monitor: scoreboard pops on every handshake; pulse widths are tracked.
  always @(negedge fastClk) begin
    logic [38:0] e;
    if (rst) begin
      arag_prev = 1'b0;
      err_prev  = 1'b0;
    end else begin
      if (rxValid && rxReady) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got word %0h, required no word", rxData);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", 32'(rxData), 32'(e[22:0]));
          check("rx_cycle", 32'(cycle), 32'(e[38:23]));
        end
      end
      if (arag && !arag_prev) arag_pulses++;
      if (arag && arag_prev) begin
        total++;
        bad++;
        $display("FAIL arag_width: got high 2+ cycles, required 1");
      end
      if (frameErr && !err_prev) err_pulses++;
      if (frameErr && err_prev) begin
        total++;
        bad++;
        $display("FAIL frameerr_width: got high 2+ cycles, required 1");
      end
      arag_prev = arag;
      err_prev  = frameErr;
    end
  end

  initial begin
    logic [29:0] seq30;
    logic [39:0] seq40;

    rst = 1'b1; portBus = 1'b0; dataBus = 1'b0; rxReady = 1'b1;
    tick(); tick();
    check("rst_rxdata", 32'(rxData), 0);
    check("rst_rxvalid", 32'(rxValid), 0);
    check("rst_arag", 32'(arag), 0);
    check("rst_cycle", 32'(cycle), 0);
    rst = 1'b0;
    tick();

    // Basic frame and latency
    exp_q.push_back({16'd1, 23'h5A5A5A});
    send_word(23'h5A5A5A, 23, 1'b1);
    check("lat_early_valid", 32'(rxValid), 0);
    tick();
    check("lat_valid", 32'(rxValid), 1);
    check("lat_arag", 32'(arag), 1);
    check("lat_data", 32'(rxData), 32'h5A5A5A);
    check("lat_cycle", 32'(cycle), 1);
    tick();
    check("ack_arag_low", 32'(arag), 0);
    check("consumed_valid", 32'(rxValid), 0);
    tick(); tick();

    // Truncated frame then a good one
    send_word(23'h155555, 10, 1'b1);
    tick();
    check("trunc_err", 32'(frameErr), 1);
    tick();
    check("trunc_err_low", 32'(frameErr), 0);
    check("trunc_valid", 32'(rxValid), 0);
    check("trunc_cycle", 32'(cycle), 1);
    check("trunc_data", 32'(rxData), 32'h5A5A5A);
    exp_q.push_back({16'd2, 23'h000001});
    send_word(23'h000001, 23, 1'b1);
    tick(); tick(); tick(); tick();

    // Backpressure
    rxReady = 1'b0;
    exp_q.push_back({16'd3, 23'h111111});
    exp_q.push_back({16'd4, 23'h222222});
    send_word(23'h111111, 23, 1'b1);
    tick(); tick(); tick(); tick();
    send_word(23'h222222, 23, 1'b1);
    tick(); tick(); tick();
    check("stall_arag", 32'(arag), 0);
    check("stall_data", 32'(rxData), 32'h111111);
    check("stall_valid", 32'(rxValid), 1);
    check("stall_cycle", 32'(cycle), 3);
    rxReady = 1'b1;
    tick();
    rxReady = 1'b0;
    check("swap_valid", 32'(rxValid), 1);
    check("swap_data", 32'(rxData), 32'h222222);
    check("swap_arag", 32'(arag), 1);
    check("swap_cycle", 32'(cycle), 4);
    tick(); tick(); tick();
    rxReady = 1'b1;
    tick(); tick();

    // Counter wrap: preset the counter to its top value
    force dut.cycle = 16'hFFFF;
    tick();
    release dut.cycle;
    tick();
    exp_q.push_back({16'd0, 23'h7FFFFF});
    send_word(23'h7FFFFF, 23, 1'b1);
    tick();
    check("wrap_cycle", 32'(cycle), 0);
    check("wrap_data", 32'(rxData), 32'h7FFFFF);
    tick(); tick(); tick();

    // Reset mid-frame, portBus held high afterwards
    send_word(23'h6ABCDE, 12, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_data", 32'(rxData), 0);
    check("midrst_valid", 32'(rxValid), 0);
    check("midrst_arag", 32'(arag), 0);
    check("midrst_err", 32'(frameErr), 0);
    check("midrst_cycle", 32'(cycle), 0);
    @(posedge fastClk); #1;
    rst = 1'b0;
    arag_mark = arag_pulses;
    seq30 = {23'h2C3A5F, 7'h7F};
    exp_q.push_back({16'd1, 23'h2C3A5F});
    for (int i = 0; i < 30; i++) begin
      portBus = 1'b1;
      dataBus = seq30[29-i];
      tick();
    end
    check("postrst_arag_cnt", 32'(arag_pulses - arag_mark), 1);
    check("postrst_cycle", 32'(cycle), 1);
    check("postrst_err", 32'(err_pulses), 1);
    portBus = 1'b0;
    dataBus = 1'b0;
    tick(); tick(); tick();

    // portBus held high for 40 cycles
    arag_mark = arag_pulses;
    seq40 = {23'h3F00F0, 17'h1A5A5};
    exp_q.push_back({16'd2, 23'h3F00F0});
    for (int i = 0; i < 40; i++) begin
      portBus = 1'b1;
      dataBus = seq40[39-i];
      tick();
    end
    check("long_arag_cnt", 32'(arag_pulses - arag_mark), 1);
    check("long_cycle", 32'(cycle), 2);
    portBus = 1'b0;
    dataBus = 1'b0;
    tick(); tick(); tick(); tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 0);
    check("arag_total", 32'(arag_pulses), 7);
    check("err_total", 32'(err_pulses), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_core_com_receiver
`default_nettype wire
